fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC loaded on reset.
REQ-002 SHALL have parameter MEM_WORDS, default 128: instruction-memory depth in words; the legal PC range is 0 to MEM_WORDS*4-4.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; reset is not synchronised inside the block.
REQ-004 Port list (name, direction, width, meaning):
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous active-low reset.
- Stall  in  1  hold PC and IF registers.
- Branch  in  1  taken branch from decode.
- BranchOffset  in  16  word offset, signed.
- Jump  in  1  J-type redirect.
- JumpIndex  in  26  J-type target field.
- JumpReg  in  1  jr redirect.
- JumpRegAddr  in  32  jr target.
- Instruction  in  32  word returned combinationally by instruction memory.
- PCAddress  out  32  fetch address to memory; equals PC.
- IF_Instruction  out  32  registered fetched word.
- IF_PCPlus4  out  32  registered PC+4 of that word.
- IF_Valid  out  1  IF registers hold a live instruction.
- Halted  out  1  self-loop detected.
- Fault  out  1  illegal fetch address.

Function
REQ-005 SHALL implement states BOOT, RUN and HALT.
- Reset forces BOOT.
- BOOT lasts exactly one cycle, then goes to RUN.
- HALT is left only by reset.
REQ-006 In BOOT, SHALL hold PC, keep IF_Valid=0 and latch nothing.
REQ-007 In RUN with Stall=0 and no redirect, each edge SHALL perform:
- IF_Instruction<=Instruction
- IF_PCPlus4<=PC+4
- IF_Valid<=1
- PC<=PC+4
REQ-008 A redirect SHALL be recognised only when IF_Valid=1 and Stall=0.
REQ-009 Redirect priority SHALL be JumpReg > Jump > Branch.
REQ-010 Redirect targets SHALL be computed as follows:
- Branch: IF_PCPlus4 + (sign-extended BranchOffset << 2).
- Jump: {IF_PCPlus4[31:28], JumpIndex, 2'b00}.
- JumpReg: JumpRegAddr.
REQ-011 On a redirect edge, SHALL set PC<=target and IF_Valid<=0; the word fetched in that cycle is discarded (one-bubble flush).
REQ-012 Stall=1 in RUN SHALL hold PC, IF_Instruction, IF_PCPlus4 and IF_Valid unchanged; redirect inputs are ignored while stalled.
REQ-013 All PC arithmetic SHALL be unsigned modulo 2^32.
REQ-014 A recognised redirect whose target equals IF_PCPlus4-4 (branch/jump to self) SHALL perform all of the following on that edge:
- Enter HALT.
- Set Halted=1.
- Set IF_Valid<=0.
- Set PC<=target.
REQ-015 A JumpReg target with bits[1:0]≠0 SHALL, on that edge, enter HALT with Fault=1 and IF_Valid<=0; PC is not updated.
REQ-016 In RUN with Stall=0 and no redirect, if PC ≥ MEM_WORDS*4, the block SHALL NOT latch the word; it SHALL enter HALT with Fault=1 and IF_Valid<=0.
REQ-017 When Fault and self-loop conditions coincide, SHALL set Fault=1 and Halted=0.
REQ-018 In HALT, SHALL hold PC, IF_Valid=0, and keep Halted and Fault sticky.
REQ-019 PCAddress SHALL be combinational from the PC register only; no combinational path from any input to any output.

Reset
REQ-020 While Reset=0, asynchronously, SHALL force:
- PC=RESET_PC
- IF_Instruction=0
- IF_PCPlus4=0
- IF_Valid=0
- Halted=0
- Fault=0
- state=BOOT
REQ-021 Reset asserted mid-stall, mid-redirect or in HALT SHALL abandon all in-flight state; the first valid instruction after release is the word at RESET_PC.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release, memory word i = i*4 (modelled combinationally), no control -> IF_Valid rises on the second edge with IF_Instruction=0, IF_PCPlus4=4; then increments by 4 each cycle.
- Branch=1, BranchOffset=16'hfff4, IF_PCPlus4=0x60 -> next PC=0x30, one bubble (IF_Valid=0), then IF_Instruction=mem[12].
- Jump=1 and Branch=1 together, JumpIndex=0x000001A, IF_PCPlus4=0x40 -> PC=0x68; Branch ignored.
- Stall=1 for 3 cycles with Branch=1 asserted -> PC and IF registers unchanged for all 3; after Stall falls, the branch is taken once.
- Branch=1, BranchOffset=16'hffff, IF_PCPlus4=0x9C -> Halted=1, PC=0x98, IF_Valid stays 0 until Reset=0.
- Sequential fetch reaches PC=0x200 (MEM_WORDS=128) -> Fault=1, no latch; JumpReg=1, JumpRegAddr=0x42 -> Fault=1; reset in HALT clears both flags.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address,
// and registers the fetched word. It also applies decode-stage redirects
// (branch, jump, jr) with a one-bubble flush, and stops on self-loops or
// illegal fetch addresses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          MEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [15:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegAddr,
  input  logic [31:0] Instruction,
  output logic [31:0] PCAddress,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCPlus4,
  output logic        IF_Valid,
  output logic        Halted,
  output logic        Fault
);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pcplus4_q, if_pcplus4_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        jr_misaligned;
  logic        self_loop;

  // Redirect target selection (JumpReg > Jump > Branch) and hazard detection.
  always_comb begin
    branch_target = if_pcplus4_q + {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
    jump_target   = {if_pcplus4_q[31:28], JumpIndex, 2'b00};
    redirect      = if_valid_q && (JumpReg || Jump || Branch);
    jr_misaligned = JumpReg && (JumpRegAddr[1:0] != 2'b00);
    if (JumpReg) begin
      target = JumpRegAddr;
    end else if (Jump) begin
      target = jump_target;
    end else begin
      target = branch_target;
    end
    // A redirect back to the word that issued it can never make progress.
    self_loop = (target == (if_pcplus4_q - 32'd4));
  end

  // Next-state and next-register computation; everything holds by default.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_instr_d   = if_instr_q;
    if_pcplus4_d = if_pcplus4_q;
    if_valid_d   = if_valid_q;
    halted_d     = halted_q;
    fault_d      = fault_q;

    case (state_q)
      BOOT: begin
        if_valid_d = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        if (!Stall) begin
          if (redirect) begin
            if_valid_d = 1'b0;
            if (jr_misaligned) begin
              // Fault wins over a coincident self-loop; PC is left alone.
              fault_d  = 1'b1;
              halted_d = 1'b0;
              state_d  = HALT;
            end else if (self_loop) begin
              halted_d = 1'b1;
              pc_d     = target;
              state_d  = HALT;
            end else begin
              pc_d = target;
            end
          end else if (pc_q >= PC_LIMIT) begin
            // Out-of-range fetch: do not latch whatever memory returned.
            if_valid_d = 1'b0;
            fault_d    = 1'b1;
            state_d    = HALT;
          end else begin
            if_instr_d   = Instruction;
            if_pcplus4_d = pc_q + 32'd4;
            if_valid_d   = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        if_valid_d = 1'b0;
        state_d    = BOOT;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      if_instr_q   <= 32'd0;
      if_pcplus4_q <= 32'd0;
      if_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_instr_q   <= if_instr_d;
      if_pcplus4_q <= if_pcplus4_d;
      if_valid_q   <= if_valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  assign PCAddress      = pc_q;
  assign IF_Instruction = if_instr_q;
  assign IF_PCPlus4     = if_pcplus4_q;
  assign IF_Valid       = if_valid_q;
  assign Halted         = halted_q;
  assign Fault          = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenario bench for fetch_unit with a combinational memory model
// (word i holds i*4) and a queue of expected {instruction, pc+4} pairs.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Branch;
  logic [15:0] BranchOffset;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:0] JumpRegAddr;
  logic [31:0] Instruction;
  logic [31:0] PCAddress;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCPlus4;
  logic        IF_Valid;
  logic        Halted;
  logic        Fault;

  logic [31:0] mem [0:127];
  logic [63:0] exp_q [$];
  logic [31:0] exp_pc;
  int          errors;
  int          checks;

  fetch_unit #(
    .RESET_PC (32'h00000000),
    .MEM_WORDS(128)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Branch        (Branch),
    .BranchOffset  (BranchOffset),
    .Jump          (Jump),
    .JumpIndex     (JumpIndex),
    .JumpReg       (JumpReg),
    .JumpRegAddr   (JumpRegAddr),
    .Instruction   (Instruction),
    .PCAddress     (PCAddress),
    .IF_Instruction(IF_Instruction),
    .IF_PCPlus4    (IF_PCPlus4),
    .IF_Valid      (IF_Valid),
    .Halted        (Halted),
    .Fault         (Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Instruction = (PCAddress < 32'd512) ? mem[PCAddress[8:2]] : 32'hDEADBEEF;

  task automatic clear_ctrl();
    Stall        = 1'b0;
    Branch       = 1'b0;
    BranchOffset = 16'h0000;
    Jump         = 1'b0;
    JumpIndex    = 26'h0;
    JumpReg      = 1'b0;
    JumpRegAddr  = 32'h0;
  endtask

  // Reset, release, and step past the BOOT edge; next edge fetches RESET_PC.
  task automatic do_reset();
    @(negedge Clk);
    clear_ctrl();
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    exp_pc = 32'h0;
    exp_q.delete();
  endtask

  // Sequential fetch of n words: push the expected pair, clock, pop and compare.
  task automatic run_seq(input int n);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({mem[exp_pc[8:2]], exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
      @(negedge Clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL seq_queue: scoreboard empty at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (IF_Instruction !== e[63:32]) begin
          errors++;
          $display("FAIL seq_instr: got %h expected %h", IF_Instruction, e[63:32]);
        end
        checks++;
        if (IF_PCPlus4 !== e[31:0]) begin
          errors++;
          $display("FAIL seq_pcplus4: got %h expected %h", IF_PCPlus4, e[31:0]);
        end
      end
      checks++;
      if (IF_Valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_valid: got %b expected 1", IF_Valid);
      end
      checks++;
      if (PCAddress !== exp_pc) begin
        errors++;
        $display("FAIL seq_pc: got %h expected %h", PCAddress, exp_pc);
      end
    end
  endtask

  task automatic test_reset();
    clear_ctrl();
    Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (PCAddress !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", PCAddress); end
    checks++;
    if (IF_Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", IF_Instruction); end
    checks++;
    if (IF_PCPlus4 !== 32'h0) begin errors++; $display("FAIL rst_pcplus4: got %h expected 0", IF_PCPlus4); end
    checks++;
    if ({IF_Valid, Halted, Fault} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags: got valid/halted/fault=%b expected 000", {IF_Valid, Halted, Fault});
    end
    Reset = 1'b1;
    @(negedge Clk);
    // BOOT edge: PC held, nothing latched.
    checks++;
    if (IF_Valid !== 1'b0 || PCAddress !== 32'h0) begin
      errors++;
      $display("FAIL boot_hold: got valid=%b pc=%h expected 0/0", IF_Valid, PCAddress);
    end
    exp_pc = 32'h0;
    exp_q.delete();
    run_seq(6);
    // Asynchronous reset in mid-run, sampled before the next clock edge.
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (PCAddress !== 32'h0 || IF_Valid !== 1'b0 || IF_Instruction !== 32'h0) begin
      errors++;
      $display("FAIL async_rst: got pc=%h valid=%b instr=%h expected 0/0/0", PCAddress, IF_Valid, IF_Instruction);
    end
    Reset = 1'b1;
  endtask

  task automatic test_branch();
    do_reset();
    run_seq(24);
    Branch       = 1'b1;
    BranchOffset = 16'hfff4;
    @(negedge Clk);
    checks++;
    if (PCAddress !== 32'h30) begin errors++; $display("FAIL br_pc: got %h expected 30", PCAddress); end
    checks++;
    if (IF_Valid !== 1'b0) begin errors++; $display("FAIL br_bubble: got %b expected 0", IF_Valid); end
    // Branch left high through the bubble: must be ignored while IF_Valid=0.
    exp_pc = 32'h30;
    run_seq(1);
    clear_ctrl();
    run_seq(2);
  endtask

  task automatic test_jump();
    do_reset();
    run_seq(16);
    Jump         = 1'b1;
    JumpIndex    = 26'h000001A;
    Branch       = 1'b1;
    BranchOffset = 16'h0004;
    @(negedge Clk);
    clear_ctrl();
    checks++;
    if (PCAddress !== 32'h68) begin errors++; $display("FAIL jmp_pc: got %h expected 68", PCAddress); end
    checks++;
    if (IF_Valid !== 1'b0 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL jmp_bubble: got valid=%b halted=%b expected 0/0", IF_Valid, Halted);
    end
    exp_pc = 32'h68;
    run_seq(2);
  endtask

  task automatic test_stall();
    do_reset();
    run_seq(4);
    Stall        = 1'b1;
    Branch       = 1'b1;
    BranchOffset = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (PCAddress !== 32'h10 || IF_Instruction !== 32'h0C || IF_PCPlus4 !== 32'h10 || IF_Valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got pc=%h instr=%h pc4=%h valid=%b expected 10/0c/10/1",
                 i, PCAddress, IF_Instruction, IF_PCPlus4, IF_Valid);
      end
    end
    Stall = 1'b0;
    @(negedge Clk);
    clear_ctrl();
    checks++;
    if (PCAddress !== 32'h20 || IF_Valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_branch: got pc=%h valid=%b expected 20/0", PCAddress, IF_Valid);
    end
    exp_pc = 32'h20;
    run_seq(2);
  endtask

  task automatic test_self_loop();
    do_reset();
    run_seq(39);
    Branch       = 1'b1;
    BranchOffset = 16'hffff;
    @(negedge Clk);
    clear_ctrl();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Halted !== 1'b1 || Fault !== 1'b0 || PCAddress !== 32'h98 || IF_Valid !== 1'b0) begin
        errors++;
        $display("FAIL self_loop%0d: got halted=%b fault=%b pc=%h valid=%b expected 1/0/98/0",
                 i, Halted, Fault, PCAddress, IF_Valid);
      end
      @(negedge Clk);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (Halted !== 1'b0 || PCAddress !== 32'h0) begin
      errors++;
      $display("FAIL halt_rst: got halted=%b pc=%h expected 0/0", Halted, PCAddress);
    end
    do_reset();
    run_seq(2);
  endtask

  task automatic test_fault_range();
    do_reset();
    run_seq(128);
    @(negedge Clk);
    checks++;
    if (Fault !== 1'b1 || Halted !== 1'b0 || IF_Valid !== 1'b0) begin
      errors++;
      $display("FAIL range_flags: got fault=%b halted=%b valid=%b expected 1/0/0", Fault, Halted, IF_Valid);
    end
    checks++;
    if (IF_Instruction !== 32'h1FC || IF_PCPlus4 !== 32'h200 || PCAddress !== 32'h200) begin
      errors++;
      $display("FAIL range_nolatch: got instr=%h pc4=%h pc=%h expected 1fc/200/200",
               IF_Instruction, IF_PCPlus4, PCAddress);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (Fault !== 1'b0 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL range_rst: got fault=%b halted=%b expected 0/0", Fault, Halted);
    end
    Reset = 1'b1;
  endtask

  task automatic test_jump_reg();
    do_reset();
    run_seq(3);
    JumpReg     = 1'b1;
    JumpRegAddr = 32'h100;
    Jump        = 1'b1;
    JumpIndex   = 26'h1;
    @(negedge Clk);
    clear_ctrl();
    checks++;
    if (PCAddress !== 32'h100 || IF_Valid !== 1'b0) begin
      errors++;
      $display("FAIL jr_pc: got pc=%h valid=%b expected 100/0", PCAddress, IF_Valid);
    end
    exp_pc = 32'h100;
    run_seq(2);
    JumpReg     = 1'b1;
    JumpRegAddr = 32'h42;
    @(negedge Clk);
    clear_ctrl();
    checks++;
    if (Fault !== 1'b1 || Halted !== 1'b0 || PCAddress !== 32'h108 || IF_Valid !== 1'b0) begin
      errors++;
      $display("FAIL jr_fault: got fault=%b halted=%b pc=%h valid=%b expected 1/0/108/0",
               Fault, Halted, PCAddress, IF_Valid);
    end
    @(negedge Clk);
    checks++;
    if (Fault !== 1'b1 || PCAddress !== 32'h108) begin
      errors++;
      $display("FAIL jr_sticky: got fault=%b pc=%h expected 1/108", Fault, PCAddress);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (Fault !== 1'b0 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL jr_rst: got fault=%b halted=%b expected 0/0", Fault, Halted);
    end
    Reset = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
    Reset = 1'b0;
    clear_ctrl();
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_self_loop();
    test_fault_range();
    test_jump_reg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
